// File: rtl/npu_buf_pkg.sv
// -----------------------------------------------------------------------------
// npu_buf_pkg
// Shared sizing defaults for the NPU output buffer path. The output address
// generator and output_accum_buffer both take their defaults from here so the
// two blocks agree on bank count, depth and partial-sum width.
//
// Contents:
//   RAM_O_SIZE_DEF  words per output bank
//   ARRAY_M_DEF     systolic-array columns (= number of banks)
//   DATA_WIDTH_DEF  partial-sum width in bits
//   addr_width_of() bank address width for a given depth
// -----------------------------------------------------------------------------
package npu_buf_pkg;

    localparam int RAM_O_SIZE_DEF = 256;
    localparam int ARRAY_M_DEF    = 8;
    localparam int DATA_WIDTH_DEF = 32;

    // Address width for a bank of the given depth; a depth of 1 still gets
    // one address bit so port widths never collapse to zero.
    function automatic int addr_width_of(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : npu_buf_pkg

// File: rtl/output_accum_bank.sv
// -----------------------------------------------------------------------------
// output_accum_bank
// One column's output bank: a synchronous-read / synchronous-write RAM with a
// 2-stage read-modify-write pipeline (S0 issues the RAM read, S1 computes and
// commits). S1 either overwrites the stored word or adds to it. A same-address
// request arriving while S1 is busy captures S1's result instead of the stale
// RAM word. The RAM read port is shared with the host read path; the top level
// only grants a host read when no bank has a write request.
//
// Ports:
//   clk          clock, posedge
//   reset        synchronous, active-high
//   wr_en_i      write request (S0)
//   wr_addr_i    write address
//   wr_data_i    write data
//   accum_i      1 = accumulate into stored word, 0 = overwrite
//   rd_acc_i     host read accepted this cycle (uses the S0 read slot)
//   rd_addr_i    host read address
//   rd_data_o    host read result, valid while rd_valid_o is high, else 0
//   rd_valid_o   one-cycle pulse, one cycle after an accepted read
//   s1_valid_o   a write is in S1 this cycle
// -----------------------------------------------------------------------------
module output_accum_bank
    import npu_buf_pkg::*;
#(
    parameter int RAM_O_SIZE = RAM_O_SIZE_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = addr_width_of(RAM_O_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  accum_i,
    input  logic                  rd_acc_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  s1_valid_o
);

    // RAM storage and its registered read output.
    logic [DATA_WIDTH-1:0] mem_q [RAM_O_SIZE];
    logic [DATA_WIDTH-1:0] ram_dout_q;

    // S1 pipeline registers.
    logic                  s1_valid_q, s1_valid_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  accum_q;
    logic                  fwd_q, fwd_d;
    logic [DATA_WIDTH-1:0] fwd_val_q;

    // Host read return registers.
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_fwd_q, rd_fwd_d;
    logic [DATA_WIDTH-1:0] rd_fwd_val_q;

    // Combinational datapath.
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] old_val;
    logic [DATA_WIDTH-1:0] new_val;
    logic                  s1_hit_wr;
    logic                  s1_hit_rd;

    always_comb begin
        // A write request owns the read port; the host only gets it when the
        // top level has seen no write requests at all.
        ram_re    = wr_en_i | rd_acc_i;
        ram_raddr = wr_en_i ? wr_addr_i : rd_addr_i;

        old_val   = fwd_q ? fwd_val_q : ram_dout_q;
        // Modulo 2^DATA_WIDTH; overflow wraps.
        new_val   = accum_q ? (old_val + data_q) : data_q;

        // The RAM read issued in the same cycle as an S1 commit returns the
        // pre-commit word, so a matching S1 address must be forwarded.
        s1_hit_wr = s1_valid_q & (addr_q == wr_addr_i);
        s1_hit_rd = s1_valid_q & (addr_q == rd_addr_i);

        ram_we     = s1_valid_q & ~reset;

        s1_valid_d = wr_en_i;
        fwd_d      = wr_en_i ? s1_hit_wr : fwd_q;
        rd_valid_d = rd_acc_i;
        rd_fwd_d   = rd_acc_i ? s1_hit_rd : rd_fwd_q;
    end

    always_ff @(posedge clk) begin
        if (ram_re) begin
            ram_dout_q <= mem_q[ram_raddr];
        end
        if (ram_we) begin
            mem_q[addr_q] <= new_val;
        end
    end

    // Control state, cleared by reset; requests seen during reset are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            fwd_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_fwd_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            fwd_q      <= fwd_d;
            rd_valid_q <= rd_valid_d;
            rd_fwd_q   <= rd_fwd_d;
        end
    end

    // Datapath registers need no reset: they are only consumed under a valid
    // bit that reset does clear.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            addr_q    <= wr_addr_i;
            data_q    <= wr_data_i;
            accum_q   <= accum_i;
            fwd_val_q <= new_val;
        end
        if (rd_acc_i) begin
            rd_fwd_val_q <= new_val;
        end
    end

    // Host data comes straight off the RAM output register (or the captured
    // forward value) and is forced to 0 outside the valid cycle.
    always_comb begin
        rd_data_o = '0;
        if (rd_valid_q) begin
            rd_data_o = rd_fwd_q ? rd_fwd_val_q : ram_dout_q;
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign s1_valid_o = s1_valid_q;

endmodule : output_accum_bank

// File: rtl/output_accum_buffer.sv
// -----------------------------------------------------------------------------
// output_accum_buffer
// Banked output RAM for the systolic array: one output_accum_bank per column.
// Each bank takes its own address/data/enable slice from the packed buses and
// runs an independent overwrite/accumulate pipeline. A single host read port
// reads the same address from every bank at once; writes always win the
// shared read port.
//
// Ports:
//   clk          clock, posedge
//   reset        synchronous, active-high
//   wr_addr_set  bank m address at [ADDR_WIDTH*m +: ADDR_WIDTH]
//   wr_en_set    per-bank write request
//   wr_data_set  bank m data at [DATA_WIDTH*m +: DATA_WIDTH]
//   accum        1 = accumulate, 0 = overwrite (shared by all banks)
//   rd_en        host read request (held by host until accepted)
//   rd_addr      host read address, common to all banks
//   rd_ready     host read accepted this cycle (no write requests present)
//   rd_data      read result, bank m in slice m
//   rd_valid     rd_data valid, one cycle after acceptance
//   pending      at least one bank has a write in S1
// -----------------------------------------------------------------------------
module output_accum_buffer
    import npu_buf_pkg::*;
#(
    parameter int RAM_O_SIZE     = RAM_O_SIZE_DEF,
    parameter int ARRAY_M        = ARRAY_M_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH     = addr_width_of(RAM_O_SIZE),
    parameter int ADDR_SET_WIDTH = ADDR_WIDTH * ARRAY_M
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_SET_WIDTH-1:0]     wr_addr_set,
    input  logic [ARRAY_M-1:0]            wr_en_set,
    input  logic [DATA_WIDTH*ARRAY_M-1:0] wr_data_set,
    input  logic                          accum,
    input  logic                          rd_en,
    input  logic [ADDR_WIDTH-1:0]         rd_addr,
    output logic                          rd_ready,
    output logic [DATA_WIDTH*ARRAY_M-1:0] rd_data,
    output logic                          rd_valid,
    output logic                          pending
);

    logic               rd_acc;
    logic [ARRAY_M-1:0] bank_rd_valid;
    logic [ARRAY_M-1:0] bank_s1_valid;

    assign rd_ready = ~|wr_en_set;
    assign rd_acc   = rd_en & rd_ready;

    for (genvar m = 0; m < ARRAY_M; m++) begin : g_bank
        output_accum_bank #(
            .RAM_O_SIZE (RAM_O_SIZE),
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk        (clk),
            .reset      (reset),
            .wr_en_i    (wr_en_set[m]),
            .wr_addr_i  (wr_addr_set[ADDR_WIDTH*m +: ADDR_WIDTH]),
            .wr_data_i  (wr_data_set[DATA_WIDTH*m +: DATA_WIDTH]),
            .accum_i    (accum),
            .rd_acc_i   (rd_acc),
            .rd_addr_i  (rd_addr),
            .rd_data_o  (rd_data[DATA_WIDTH*m +: DATA_WIDTH]),
            .rd_valid_o (bank_rd_valid[m]),
            .s1_valid_o (bank_s1_valid[m])
        );
    end

    // All banks see the same accept, so their valid bits move together.
    assign rd_valid = |bank_rd_valid;
    assign pending  = |bank_s1_valid;

endmodule : output_accum_buffer

// File: tb/tb_output_accum_buffer.sv
module tb_output_accum_buffer;

    localparam int M  = 8;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int OP_IDLE = 0;
    localparam int OP_WR   = 1;
    localparam int OP_RD   = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [AW*M-1:0] wr_addr_set;
    logic [M-1:0]    wr_en_set;
    logic [DW*M-1:0] wr_data_set;
    logic            accum;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic            rd_ready;
    logic [DW*M-1:0] rd_data;
    logic            rd_valid;
    logic            pending;

    always #5 clk = ~clk;

    output_accum_buffer #(
        .RAM_O_SIZE (256),
        .ARRAY_M    (M),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_addr_set (wr_addr_set),
        .wr_en_set   (wr_en_set),
        .wr_data_set (wr_data_set),
        .accum       (accum),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .pending     (pending)
    );

    typedef struct {
        int          op;
        int          bank;
        int          addr;
        logic [31:0] data;
        logic        acc;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];
    vec_t prev;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en_set   = '0;
        wr_addr_set = '0;
        wr_data_set = '0;
        accum       = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;
    endtask

    task automatic set_wr(input int b, input int a, input logic [31:0] d);
        wr_en_set[b]             = 1'b1;
        wr_addr_set[AW*b +: AW]  = a[AW-1:0];
        wr_data_set[DW*b +: DW]  = d;
    endtask

    task automatic set_rd(input int a);
        rd_en   = 1'b1;
        rd_addr = a[AW-1:0];
    endtask

    function automatic vec_t mk(input int op, input int bank, input int addr,
                                input logic [31:0] data, input logic acc,
                                input logic [31:0] exp);
        vec_t v;
        v.op = op; v.bank = bank; v.addr = addr;
        v.data = data; v.acc = acc; v.exp = exp;
        return v;
    endfunction

    // Checks the outputs produced by the previously applied vector.
    task automatic check_prev(input vec_t p);
        chk("pending", {31'd0, pending}, {31'd0, p.op == OP_WR});
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, p.op == OP_RD});
        if (p.op == OP_RD)
            chk($sformatf("rd_data b%0d a%0d", p.bank, p.addr), rd_data[DW*p.bank +: DW], p.exp);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset pending", {31'd0, pending}, 32'd0);
        chk("reset rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset rd_data zero", {31'd0, |rd_data}, 32'd0);
        #1 chk("reset rd_ready idle", {31'd0, rd_ready}, 32'd1);
        wr_en_set[2] = 1'b1;
        #1 chk("reset rd_ready wr", {31'd0, rd_ready}, 32'd0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;

        // Overwrite, forwarded accumulate chain, wrap, non-forwarded accumulates
        vecs.push_back(mk(OP_WR,   0,  5, 32'd7,          1'b0, 32'd0));
        vecs.push_back(mk(OP_IDLE, 0,  0, 32'd0,          1'b0, 32'd0));
        vecs.push_back(mk(OP_RD,   0,  5, 32'd0,          1'b0, 32'd7));
        vecs.push_back(mk(OP_WR,   0,  3, 32'd10,         1'b0, 32'd0));
        vecs.push_back(mk(OP_WR,   0,  3, 32'd1,          1'b1, 32'd0));
        vecs.push_back(mk(OP_WR,   0,  3, 32'd2,          1'b1, 32'd0));
        vecs.push_back(mk(OP_WR,   0,  3, 32'd3,          1'b1, 32'd0));
        vecs.push_back(mk(OP_RD,   0,  3, 32'd0,          1'b0, 32'd16));
        vecs.push_back(mk(OP_IDLE, 0,  0, 32'd0,          1'b0, 32'd0));
        vecs.push_back(mk(OP_RD,   0,  3, 32'd0,          1'b0, 32'd16));
        vecs.push_back(mk(OP_WR,   1, 20, 32'hFFFF_FFFF,  1'b0, 32'd0));
        vecs.push_back(mk(OP_IDLE, 0,  0, 32'd0,          1'b0, 32'd0));
        vecs.push_back(mk(OP_WR,   1, 20, 32'd2,          1'b1, 32'd0));
        vecs.push_back(mk(OP_IDLE, 0,  0, 32'd0,          1'b0, 32'd0));
        vecs.push_back(mk(OP_RD,   1, 20, 32'd0,          1'b0, 32'h0000_0001));
        vecs.push_back(mk(OP_WR,   2,  1, 32'd5,          1'b0, 32'd0));
        vecs.push_back(mk(OP_WR,   2,  2, 32'd6,          1'b0, 32'd0));
        vecs.push_back(mk(OP_WR,   2,  1, 32'd1,          1'b1, 32'd0));
        vecs.push_back(mk(OP_WR,   2,  2, 32'd1,          1'b1, 32'd0));
        vecs.push_back(mk(OP_IDLE, 0,  0, 32'd0,          1'b0, 32'd0));
        vecs.push_back(mk(OP_RD,   2,  1, 32'd0,          1'b0, 32'd6));
        vecs.push_back(mk(OP_RD,   2,  2, 32'd0,          1'b0, 32'd7));
        vecs.push_back(mk(OP_IDLE, 0,  0, 32'd0,          1'b0, 32'd0));

        prev = mk(OP_IDLE, 0, 0, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check_prev(prev);
            idle_inputs();
            if (vecs[i].op == OP_WR) begin
                set_wr(vecs[i].bank, vecs[i].addr, vecs[i].data);
                accum = vecs[i].acc;
            end else if (vecs[i].op == OP_RD) begin
                set_rd(vecs[i].addr);
            end
            #1 chk($sformatf("rd_ready v%0d", i), {31'd0, rd_ready},
                   {31'd0, vecs[i].op != OP_WR});
            prev = vecs[i];
        end
        @(negedge clk);
        check_prev(prev);
        idle_inputs();

        // Read blocked while any write request is present
        @(negedge clk);
        idle_inputs(); set_wr(3, 7, 32'h55); set_rd(7);
        #1 chk("blk rd_ready 0", {31'd0, rd_ready}, 32'd0);
        @(negedge clk);
        chk("blk rd_valid 0", {31'd0, rd_valid}, 32'd0);
        idle_inputs(); set_wr(3, 7, 32'h11); accum = 1'b1; set_rd(7);
        #1 chk("blk rd_ready 1", {31'd0, rd_ready}, 32'd0);
        @(negedge clk);
        chk("blk rd_valid 1", {31'd0, rd_valid}, 32'd0);
        idle_inputs(); set_wr(4, 0, 32'd9); set_rd(7);
        #1 chk("blk rd_ready 2", {31'd0, rd_ready}, 32'd0);
        @(negedge clk);
        chk("blk rd_valid 2", {31'd0, rd_valid}, 32'd0);
        idle_inputs(); set_rd(7);
        #1 chk("blk rd_ready free", {31'd0, rd_ready}, 32'd1);
        @(negedge clk);
        chk("blk rd_valid done", {31'd0, rd_valid}, 32'd1);
        chk("blk rd_data", rd_data[DW*3 +: DW], 32'h66);
        idle_inputs();
        @(negedge clk);
        chk("blk rd_valid pulse", {31'd0, rd_valid}, 32'd0);

        // Eight banks: clear addresses 10..17 everywhere, then one wide write
        for (int a = 10; a < 18; a++) begin
            @(negedge clk);
            idle_inputs();
            for (int m = 0; m < M; m++) set_wr(m, a, 32'd0);
        end
        @(negedge clk);
        idle_inputs();
        for (int m = 0; m < M; m++) set_wr(m, 10 + m, 32'hA000_0000 + 32'(m * 17 + 1));
        for (int k = 0; k < M; k++) begin
            @(negedge clk);
            idle_inputs(); set_rd(10 + k);
            @(negedge clk);
            idle_inputs();
            chk($sformatf("m8 rd_valid a%0d", 10 + k), {31'd0, rd_valid}, 32'd1);
            for (int m = 0; m < M; m++)
                chk($sformatf("m8 a%0d slice%0d", 10 + k, m), rd_data[DW*m +: DW],
                    (m == k) ? 32'hA000_0000 + 32'(m * 17 + 1) : 32'd0);
        end

        // Reset during the S1 cycle of a write
        @(negedge clk);
        idle_inputs(); set_wr(5, 9, 32'd4);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        idle_inputs(); set_wr(5, 9, 32'h77);
        @(negedge clk);
        chk("rst pre pending", {31'd0, pending}, 32'd1);
        idle_inputs(); reset = 1'b1; set_wr(5, 9, 32'hAA); set_rd(9);
        #1 chk("rst rd_ready follows wr", {31'd0, rd_ready}, 32'd0);
        @(negedge clk);
        chk("rst pending", {31'd0, pending}, 32'd0);
        chk("rst rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst rd_data zero", {31'd0, |rd_data}, 32'd0);
        idle_inputs(); set_rd(9);
        #1 chk("rst rd_ready idle", {31'd0, rd_ready}, 32'd1);
        @(negedge clk);
        chk("rst pending 2", {31'd0, pending}, 32'd0);
        chk("rst rd_valid 2", {31'd0, rd_valid}, 32'd0);
        idle_inputs(); reset = 1'b0;
        @(negedge clk);
        chk("post rst rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("post rst pending", {31'd0, pending}, 32'd0);
        idle_inputs(); set_rd(9);
        @(negedge clk);
        idle_inputs();
        chk("post rst rd_valid read", {31'd0, rd_valid}, 32'd1);
        chk("post rst addr9", rd_data[DW*5 +: DW], 32'd4);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_output_accum_buffer
